// File: rtl/sobel_pkg.sv
// Shared constants for the 3x3 Sobel edge-magnitude engine: width helpers,
// saturation limit and kernel weights.
package sobel_pkg;

  localparam int GRAD_GUARD = 3;
  localparam int MAG_GUARD  = 4;

  localparam int KW_EDGE   = 1;
  localparam int KW_CENTER = 2;

  function automatic int grad_width(input int pix_w);
    return pix_w + GRAD_GUARD;
  endfunction

  function automatic int mag_width(input int pix_w);
    return pix_w + MAG_GUARD;
  endfunction

  function automatic int sat_max(input int pix_w);
    return (1 << pix_w) - 1;
  endfunction

endpackage

// File: rtl/sobel_window_3x3.sv
// 3x3 sliding pixel window fed by three aligned rows, plus the line column
// counter that tags each beat as window-complete (column >= 2).
module sobel_window_3x3
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic                  sof,
  input  logic [PIX_W-1:0]      din_top,
  input  logic [PIX_W-1:0]      din_mid,
  input  logic [PIX_W-1:0]      din_bot,
  output logic [2:0][PIX_W-1:0] win_top,
  output logic [2:0][PIX_W-1:0] win_mid,
  output logic [2:0][PIX_W-1:0] win_bot,
  output logic                  win_valid,
  output logic                  win_complete
);

  localparam int COL_W = $clog2(IMG_W);

  logic [COL_W-1:0] col;
  logic [COL_W-1:0] beat_col;

  // col holds the column the next beat will land on; sof overrides it to 0
  always_comb begin
    beat_col = sof ? '0 : col;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_top      <= '0;
      win_mid      <= '0;
      win_bot      <= '0;
      col          <= '0;
      win_valid    <= 1'b0;
      win_complete <= 1'b0;
    end else begin
      win_valid    <= valid_in;
      win_complete <= valid_in && (beat_col >= COL_W'(2));
      if (valid_in) begin
        win_top <= {win_top[1:0], din_top};
        win_mid <= {win_mid[1:0], din_mid};
        win_bot <= {win_bot[1:0], din_bot};
        col     <= (beat_col == COL_W'(IMG_W - 1)) ? '0 : beat_col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/sobel_3x3_core.sv
// Streaming 3x3 Sobel |GX|+|GY| engine, saturated and replicated per channel.
// Define SOBEL_THRESH_EN to add the thresh port and binarise the output.
module sobel_3x3_core
  import sobel_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int IMG_W  = 640,
  parameter int OUT_CH = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic                    sof,
  input  logic [PIX_W-1:0]        din_top,
  input  logic [PIX_W-1:0]        din_mid,
  input  logic [PIX_W-1:0]        din_bot,
`ifdef SOBEL_THRESH_EN
  input  logic [PIX_W-1:0]        thresh,
`endif
  output logic                    valid_out,
  output logic [OUT_CH*PIX_W-1:0] dout
);

  localparam int GW = grad_width(PIX_W);
  localparam int MW = mag_width(PIX_W);

  localparam logic [MW-1:0]           SAT_MAX = MW'(sat_max(PIX_W));
  localparam logic signed [GW-1:0]    KE      = GW'(KW_EDGE);
  localparam logic signed [GW-1:0]    KC      = GW'(KW_CENTER);

  logic [2:0][PIX_W-1:0] win_top, win_mid, win_bot;
  logic                  win_valid, win_complete;

  logic signed [GW-1:0]  gx_next, gy_next, gx, gy;
  logic                  s1_valid, s1_complete;
  logic [GW-1:0]         abs_gx, abs_gy;
  logic [MW-1:0]         mag;
  logic [PIX_W-1:0]      mag_sat, px_next;

  sobel_window_3x3 #(
    .PIX_W (PIX_W),
    .IMG_W (IMG_W)
  ) u_window (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .sof          (sof),
    .din_top      (din_top),
    .din_mid      (din_mid),
    .din_bot      (din_bot),
    .win_top      (win_top),
    .win_mid      (win_mid),
    .win_bot      (win_bot),
    .win_valid    (win_valid),
    .win_complete (win_complete)
  );

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({{GRAD_GUARD{1'b0}}, p});
  endfunction

  // Index 0 is the newest (right) column, index 2 the oldest (left)
  always_comb begin
    gx_next = (KE * ext(win_top[0]) + KC * ext(win_mid[0]) + KE * ext(win_bot[0]))
            - (KE * ext(win_top[2]) + KC * ext(win_mid[2]) + KE * ext(win_bot[2]));
    gy_next = (KE * ext(win_top[2]) + KC * ext(win_top[1]) + KE * ext(win_top[0]))
            - (KE * ext(win_bot[2]) + KC * ext(win_bot[1]) + KE * ext(win_bot[0]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx          <= '0;
      gy          <= '0;
      s1_valid    <= 1'b0;
      s1_complete <= 1'b0;
    end else begin
      gx          <= gx_next;
      gy          <= gy_next;
      s1_valid    <= win_valid;
      s1_complete <= win_complete;
    end
  end

  always_comb begin
    abs_gx  = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
    abs_gy  = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
    mag     = MW'(abs_gx) + MW'(abs_gy);
    mag_sat = (mag > SAT_MAX) ? SAT_MAX[PIX_W-1:0] : mag[PIX_W-1:0];
    px_next = '0;
`ifdef SOBEL_THRESH_EN
    if (s1_complete && (mag_sat >= thresh)) begin
      px_next = SAT_MAX[PIX_W-1:0];
    end
`else
    if (s1_complete) begin
      px_next = mag_sat;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      dout      <= '0;
    end else begin
      valid_out <= s1_valid;
      dout      <= {OUT_CH{px_next}};
    end
  end

endmodule

// File: tb/tb_sobel_3x3_core.sv
// Table-driven scoreboard bench for sobel_3x3_core (PIX_W=8, IMG_W=8, OUT_CH=3).
module tb_sobel_3x3_core;

  localparam int PIX_W  = 8;
  localparam int IMG_W  = 8;
  localparam int OUT_CH = 3;
  localparam int THRESH = 40;

  typedef struct {
    logic [7:0] top;
    logic [7:0] mid;
    logic [7:0] bot;
    logic       sof;
    int         gap;
    logic [7:0] mag;
  } vec_t;

  typedef struct {
    logic [23:0] dout;
    int          cyc;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic        sof = 1'b0;
  logic [7:0]  din_top = '0;
  logic [7:0]  din_mid = '0;
  logic [7:0]  din_bot = '0;
`ifdef SOBEL_THRESH_EN
  logic [7:0]  thresh = 8'(THRESH);
`endif
  logic        valid_out;
  logic [23:0] dout;

  int   cyc = 0;
  int   check_count = 0;
  int   pass_count = 0;
  vec_t vecs[$];
  sb_t  sb_q[$];
  sb_t  mon_e;

  sobel_3x3_core #(
    .PIX_W  (PIX_W),
    .IMG_W  (IMG_W),
    .OUT_CH (OUT_CH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .sof       (sof),
    .din_top   (din_top),
    .din_mid   (din_mid),
    .din_bot   (din_bot),
`ifdef SOBEL_THRESH_EN
    .thresh    (thresh),
`endif
    .valid_out (valid_out),
    .dout      (dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Pixel patterns: 0 flat 0x40, 1 step of 10 at col 4, 2 step of 100, 3 horizontal edge
  function automatic logic [7:0] pix(input int kind, input int c, input int row);
    case (kind)
      0:       return 8'h40;
      1:       return (c < 4) ? 8'd0 : 8'd10;
      2:       return (c < 4) ? 8'd0 : 8'd100;
      default: return (row == 2) ? 8'd20 : 8'd0;
    endcase
  endfunction

  // Hand-derived saturated magnitudes for the beat landing on column c
  function automatic logic [7:0] mag(input int kind, input int c);
    case (kind)
      0:       return 8'd0;
      1:       return (c == 4 || c == 5) ? 8'd40 : 8'd0;
      2:       return (c == 4 || c == 5) ? 8'd255 : 8'd0;
      default: return (c >= 2) ? 8'd80 : 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] post(input logic [7:0] m);
`ifdef SOBEL_THRESH_EN
    return (m >= 8'(THRESH)) ? 8'hFF : 8'h00;
`else
    return m;
`endif
  endfunction

  function automatic void addLine(input int kind, input int last_col, input logic sof_first, input int gap);
    vec_t v;
    for (int c = 0; c <= last_col; c++) begin
      v.top = pix(kind, c, 0);
      v.mid = pix(kind, c, 1);
      v.bot = pix(kind, c, 2);
      v.sof = sof_first && (c == 0);
      v.gap = gap;
      v.mag = mag(kind, c);
      vecs.push_back(v);
    end
  endfunction

  task automatic applyStimulus(input vec_t v);
    sb_t e;
    @(negedge clk);
    valid_in = 1'b1;
    sof      = v.sof;
    din_top  = v.top;
    din_mid  = v.mid;
    din_bot  = v.bot;
    e.dout   = {3{post(v.mag)}};
    e.cyc    = cyc + 3;
    sb_q.push_back(e);
    for (int g = 0; g < v.gap; g++) begin
      @(negedge clk);
      valid_in = 1'b0;
      sof      = 1'b1;
      din_top  = 8'hAA;
      din_mid  = 8'h55;
      din_bot  = 8'hFF;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
      sof      = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_out) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_valid_out", 32'(valid_out), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          checkOutput("dout", 32'(dout), 32'(mon_e.dout));
          checkOutput("latency", cyc, mon_e.cyc);
        end
      end else if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
        mon_e = sb_q.pop_front();
        checkOutput("missing_valid_out", 32'(valid_out), 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting sobel_3x3_core bench");

    addLine(0, 7, 1'b1, 0);
    addLine(0, 7, 1'b0, 0);
    addLine(0, 7, 1'b0, 0);
    addLine(1, 7, 1'b0, 0);
    addLine(2, 7, 1'b0, 0);
    addLine(3, 7, 1'b0, 0);
    addLine(1, 7, 1'b0, 1);
    addLine(2, 4, 1'b0, 0);
    addLine(1, 7, 1'b1, 0);
    addLine(1, 7, 1'b0, 0);

    repeat (3) @(negedge clk);
    checkOutput("reset_valid_out", 32'(valid_out), 32'd0);
    checkOutput("reset_dout", 32'(dout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    checkOutput("idle_valid_out", 32'(valid_out), 32'd0);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Mid-line reset: beats still in flight must never surface
    for (int c = 0; c <= 4; c++) begin
      vec_t v;
      v.top = pix(1, c, 0);
      v.mid = pix(1, c, 1);
      v.bot = pix(1, c, 2);
      v.sof = 1'b0;
      v.gap = 0;
      v.mag = mag(1, c);
      applyStimulus(v);
    end
    @(negedge clk);
    valid_in = 1'b0;
    #2;
    checkOutput("pre_reset_valid_out", 32'(valid_out), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_drop_valid_out", 32'(valid_out), 32'd0);
    checkOutput("reset_drop_dout", 32'(dout), 32'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    idle(5);
    vecs.delete();
    addLine(1, 7, 1'b0, 0);
    foreach (vecs[i]) applyStimulus(vecs[i]);
    idle(1);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard_drain", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/sobel_3x3_core.md
# sobel_3x3_core

Parametrised 3x3 Sobel edge-magnitude engine for the streaming video pipeline. It receives three vertically aligned pixel rows per beat from the upstream line-buffer block and maintains a 3x3 sliding window and a column position. It computes signed horizontal and vertical gradients and emits the saturated magnitude |GX|+|GY|, replicated across output channels. Compared with the first-generation block, it adds width and channel parameters, correct signed arithmetic, saturation, line/frame alignment, a valid output and optional binarisation.

## Interface
- PIX_W, 8: pixel bit width (luma, taken from the LSBs of each row input).
- IMG_W, 640: active pixels per line; must be at least 3.
- OUT_CH, 3: number of output channels, each carrying the same magnitude.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_in  in  1  input beat qualifier; no backpressure.
- sof  in  1  start of frame; sampled only when valid_in=1; forces the current beat to column 0.
- din_top  in  PIX_W  pixel from line y-2.
- din_mid  in  PIX_W  pixel from line y-1.
- din_bot  in  PIX_W  pixel from line y.
- thresh  in  PIX_W  binarisation threshold; present only with SOBEL_THRESH_EN.
- valid_out  out  1  output beat qualifier.
- dout  out  OUT_CH*PIX_W  magnitude, replicated in each PIX_W slice.

## Operation
- Window: on each valid_in beat, every row shifts by one position: w[r][2]←w[r][1], w[r][1]←w[r][0], w[r][0]←din. Column 0 is the newest (right) pixel and column 2 is the oldest (left). The window holds its contents when valid_in=0.
- Column counter col, range 0..IMG_W-1:
  - Advances on each valid_in beat.
  - Wraps from IMG_W-1 to 0.
  - sof=1 with valid_in=1 tags the current beat as col=0, so the next beat is col=1. This takes priority over the wrap.
- Window-complete flag: the beat at col>=2. Beats at col 0 and col 1 produce dout=0, so every line yields exactly IMG_W outputs. Output k corresponds to the window centred on column k-1.
- Gradients, signed, width PIX_W+3:
  - GX = (t0+2·m0+b0) − (t2+2·m2+b2)
  - GY = (t2+2·t1+t0) − (b2+2·b1+b0)
  - Range is ±4·(2^PIX_W−1); overflow must be impossible.
- Magnitude: |GX|+|GY| computed unsigned at width PIX_W+4, then saturated to 2^PIX_W−1.
- dout = the final value replicated OUT_CH times.
- No backpressure: every accepted beat produces exactly one output beat.

## Timing
- Pipeline, counted in rising edges from E0, the edge that samples valid_in=1:
  - E0 updates the window and col.
  - E1 registers GX, GY and the valid/complete tags.
  - E2 registers dout and valid_out.
- Latency is 2 clocks: valid_out is high for the cycle following E2, one cycle per input beat.
- Throughput is 1 beat per clock. Gaps in valid_in propagate as gaps in valid_out. The pipeline stages advance every clock regardless of valid_in.
- Reset values: valid_out=0, dout=0, window=0, col=0, pipeline tags=0.
- Reset asserted mid-line drops any in-flight beats; no valid_out is produced for them.
- sof mid-line: the partial line is abandoned. The next two outputs are 0, because the stale window is masked by the col gating.

## Configuration
- SOBEL_THRESH_EN defined:
  - The thresh port exists.
  - Each channel outputs 2^PIX_W−1 when the saturated magnitude ≥ thresh, and 0 otherwise.
  - Border outputs (col<2) are 0.
  - Latency is unchanged; the comparison is folded into stage E2.
- SOBEL_THRESH_EN undefined: no thresh port; dout carries the saturated magnitude.

## Structure
- sobel_pkg holds:
  - Localparams for gradient width (PIX_W+3) and magnitude width (PIX_W+4).
  - The saturation maximum.
  - The kernel weight constants.
- One sub-module, sobel_window_3x3: the three row shift registers plus the col counter and the window-complete flag. Arithmetic stages stay in the top level.

## Test plan
All scenarios use PIX_W=8, IMG_W=8, OUT_CH=3.
- Flat image, all rows 0x40, 3 lines → every valid_out beat has dout=0; 8 outputs per line; first two outputs of each line are 0.
- Vertical step, pixels 0 for col<4 and 10 for col≥4, all rows identical → output at col 4 is 40 (GX=40, GY=0), col 5 is 40, all others 0. With step 100 the output saturates to 0xFF.
- Horizontal edge, din_top=0, din_mid=0, din_bot=20 → GY=−80, so dout=80 at col≥2 on each channel slice.
- valid_in toggled 1-0-1-0 with the vertical step pattern → outputs identical to the continuous case; valid_out spacing mirrors input gaps; latency is 2 clocks.
- sof asserted at col 5 → that beat is treated as col 0; the next two outputs are 0; the line count realigns.
- With SOBEL_THRESH_EN and thresh=40 on the step-10 image → 0xFF at col 4 and 5, 0 elsewhere. rst_n pulsed mid-line → valid_out drops within the same cycle and no stale beat appears after release.
